fft_mag_writer: RTL

//  Converts one channel's streaming complex FFT output into squared magnitudes.

---
 rtl/fft_mag_writer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fft_mag_writer.sv
`default_nettype none
// ============================================================================
// Module      : fft_mag_writer
// Description : Streams one channel's complex FFT output into squared
//               magnitudes, writes them to the bin RAM and pulses fftdone.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_mag_writer #(
    parameter int NPTS = 1024,
    parameter int AW   = 10,
    parameter int IN_W = 14,
    parameter int DW   = 28
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ast_valid,
    input  logic                   ast_sop,
    input  logic                   ast_eop,
    input  logic signed [IN_W-1:0] ast_real,
    input  logic signed [IN_W-1:0] ast_imag,
    input  logic                   ram_lock,
    output logic                   wren,
    output logic [AW-1:0]          wraddress,
    output logic [DW-1:0]          data,
    output logic                   fftdone,
    output logic                   frame_err,
    output logic [7:0]             drop_cnt
);

    localparam int SQ_W = 2*IN_W-1;
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_DROP  = 2'd2;
    localparam logic [1:0] c_FLUSH = 2'd3;
    localparam logic [AW-1:0] c_LAST = AW'(NPTS-1);

    logic [1:0]     r_state, w_state_next;
    logic [AW-1:0]  r_bin, w_idx;
    logic           w_start, w_accept, w_last_bin, w_frame_done, w_err, w_drop;

    logic                   r_v0, r_last0;
    logic [AW-1:0]          r_idx0;
    logic signed [IN_W-1:0] r_re0, r_im0;
    logic                   r_v1, r_last1, r_last2;
    logic [AW-1:0]          r_addr1;
    logic [SQ_W-1:0]        r_re_sq, r_im_sq;
    logic signed [SQ_W-1:0] w_re_prod, w_im_prod;

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_drop)
            w_state_next = c_DROP;
        else if (w_accept) begin
            if (ast_eop)         w_state_next = w_last_bin ? c_FLUSH : c_IDLE;
            else if (w_last_bin) w_state_next = c_DROP;
            else                 w_state_next = c_WRITE;
        end
        else if (r_state == c_DROP && ast_valid && ast_eop)
            w_state_next = c_IDLE;
        else if (r_state == c_FLUSH && r_last2)
            w_state_next = c_IDLE;
    end

    // FLUSH accepts a new sop like IDLE so back-to-back frames never stall.
    always_comb begin
        w_start      = ast_valid & ast_sop & ((r_state == c_IDLE) | (r_state == c_FLUSH));
        w_drop       = w_start & ram_lock;
        w_accept     = (w_start & ~ram_lock) | (ast_valid & (r_state == c_WRITE));
        w_idx        = ast_sop ? '0 : r_bin;
        w_last_bin   = (w_idx == c_LAST);
        w_frame_done = w_accept & ast_eop & w_last_bin;
        w_err        = w_accept & ((ast_sop & (r_state == c_WRITE)) | (ast_eop ^ w_last_bin));
    end

    // Squares are non-negative and below 2^(SQ_W), so the truncated product is exact.
    assign w_re_prod = SQ_W'(r_re0) * SQ_W'(r_re0);
    assign w_im_prod = SQ_W'(r_im0) * SQ_W'(r_im0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin     <= '0;
            r_v0      <= 1'b0;
            r_last0   <= 1'b0;
            r_idx0    <= '0;
            r_re0     <= '0;
            r_im0     <= '0;
            r_v1      <= 1'b0;
            r_last1   <= 1'b0;
            r_addr1   <= '0;
            r_re_sq   <= '0;
            r_im_sq   <= '0;
            r_last2   <= 1'b0;
            wren      <= 1'b0;
            wraddress <= '0;
            data      <= '0;
            fftdone   <= 1'b0;
            frame_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            r_v0    <= w_accept;
            r_last0 <= w_frame_done;
            if (w_accept) begin
                r_bin  <= w_idx + AW'(1);
                r_idx0 <= w_idx;
                r_re0  <= ast_real;
                r_im0  <= ast_imag;
            end
            r_v1    <= r_v0;
            r_last1 <= r_last0;
            if (r_v0) begin
                r_addr1 <= r_idx0;
                r_re_sq <= w_re_prod;
                r_im_sq <= w_im_prod;
            end
            wren    <= r_v1;
            r_last2 <= r_last1;
            if (r_v1) begin
                wraddress <= r_addr1;
                data      <= DW'(r_re_sq) + DW'(r_im_sq);
            end
            fftdone <= r_last2;
            if (w_err)
                frame_err <= 1'b1;
            if (w_drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire
